seq_detect_moore: RTL and testbench
===================================

# seq_detect_moore

Parametrised, runtime-programmable Moore serial sequence detector for the FSM task set. It watches a qualified serial bit stream for a pattern of 1 to MAX_LEN bits, loaded through a config port. It supports overlapping and non-overlapping detection and raises a one-cycle Moore `match` output. It also keeps a saturating match counter and flags illegal configurations.

## Interface
Parameters:
- `MAX_LEN`, default 8: maximum pattern length in bits (≥1).
- `LEN_W`, default $clog2(MAX_LEN+1): width of `cfg_len`.
- `CNT_W`, default 8: width of `match_count`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_load`  in  1  one-cycle strobe that loads `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last.
- `cfg_len`  in  LEN_W  pattern length; legal range is 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `clr_count`  in  1  synchronous clear of `match_count`.
- `din_valid`  in  1  qualifies `din`; a bit is accepted on each edge where this is high.
- `din`  in  1  serial data bit.
- `match`  out  1  Moore output; high only in state HIT.
- `match_count`  out  CNT_W  number of HIT entries; saturates at all-ones.
- `cfg_err`  out  1  high while the last load was illegal.

## Operation
States:
- UNCFG: no legal pattern is loaded.
- SEARCH: collecting and comparing bits.
- HIT: the pattern was just completed.

Datapath registers:
- Pattern, length and overlap registers, written on `cfg_load`.
- `hist`: MAX_LEN-bit shift register, updated as `{hist[MAX_LEN-2:0], din}` on each accepted bit.
- `fill`: 0..MAX_LEN count of valid history bits; increments per accepted bit and saturates at `len`.

Compare rule:
- A hit requires post-update `fill == len`.
- It also requires the low `len` bits of the post-update `hist` to equal the low `len` bits of the pattern.
- Bits above `len` are masked and do not affect the result.

Transitions, with priority `rst` > `cfg_load` > accepted bit:
- `cfg_load` with legal length: go to SEARCH, clear `hist`/`fill`, set `cfg_err` = 0. A `din_valid` bit in the same cycle is dropped.
- `cfg_load` with `cfg_len` = 0 or > MAX_LEN: go to UNCFG, set `cfg_err` = 1. Stored pattern, length and overlap registers keep their old values but are unused.
- UNCFG: `din` is ignored; the block stays in UNCFG until a legal `cfg_load`.
- SEARCH, accepted bit: go to HIT if the compare passes, otherwise stay in SEARCH.
- SEARCH, no accepted bit: hold.
- HIT, accepted bit: evaluate the compare exactly as in SEARCH. HIT is re-entered if it passes, giving back-to-back match cycles.
- HIT, no accepted bit: go to SEARCH. HIT therefore never lasts longer than one cycle without a new passing bit.

Overlap modes, applied on entry to HIT:
- Overlap = 1: `fill` stays at `len`, so suffix bits are reused for the next detection.
- Overlap = 0: `fill` is cleared to 0 on entry to HIT, so the next detection needs `len` fresh bits.

Counter:
- `match_count` increments on every entry (or re-entry) to HIT and saturates at 2^CNT_W-1.
- `clr_count` sets the count to 0. If it coincides with a HIT entry, the count becomes 1.
- `cfg_load` does not clear the count.

Reset values:
- State UNCFG, `match` = 0, `match_count` = 0, `cfg_err` = 0.
- `hist` = 0, `fill` = 0, pattern = 0, length = 0, overlap = 0.

## Timing
- `match` is decoded from the state register only (no `din` path).
- The final pattern bit is accepted at edge k, and `match` is high during cycle k+1 (one-cycle latency).
- `match_count` updates at the same edge as `match` rises.
- A config takes effect on the edge after `cfg_load` is sampled; the first bit can be accepted on the next edge.
- `rst` asserted mid-stream or during HIT: `match` is 0 and `match_count` is 0 from the next cycle.
- Throughput: one bit per clock. `din_valid` gaps of any length do not disturb the history.

## Test plan
- Reset, then load pattern 5'b11011, length 5, overlap 1; stream 1,1,0,1,1,0,1,1 with valid every cycle -> `match` pulses after bits 5 and 8, `match_count` = 2.
- Same pattern with overlap 0, same stream -> single `match` after bit 5, `match_count` = 1.
- Overlap-1 stream with 3 idle cycles inserted between every bit -> same two matches, each exactly one cycle wide; `match` = 0 during idle cycles.
- Load `cfg_len` = 0, then `cfg_len` = 9 with MAX_LEN = 8 -> `cfg_err` = 1, state UNCFG, no matches on any `din`. A following legal load clears `cfg_err`.
- CNT_W = 2, pattern length 1 = 1'b1, overlap 1, eight 1s -> `match` high 8 consecutive cycles, count 1,2,3,3,3,...
  - `clr_count` coincident with a hit -> count = 1.
- Feed 1,1,0,1, then `cfg_load` the same pattern with `din_valid` = 1, then 1 -> no match (history cleared, bit dropped).
  - Separately, assert `rst` during HIT -> `match` = 0 and `match_count` = 0 next cycle.

Source files
------------

// File: rtl/seq_detect_moore.sv
// rtl/seq_detect_moore.sv - runtime-programmable Moore serial sequence detector
// Overlapping/non-overlapping matching, saturating hit counter, illegal-config flag.
module seq_detect_moore #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  input  logic               din_valid,
  input  logic               din,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  typedef enum logic [1:0] {UNCFG, SEARCH, HIT} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_d;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_d;
  logic               ovl_q;
  logic               match_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cfg_legal;
  logic               hit;
  logic               hit_entry;

  // Compare against the history as it will look after the incoming bit.
  always_comb begin
    hist_d = MAX_LEN'({hist_q, din});
    fill_d = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hit = (fill_d == len_q) && (((hist_d ^ pat_q) & mask) == '0);
  end

  assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  assign hit_entry = !cfg_load && (state_q != UNCFG) && din_valid && hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCFG;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // A clear coinciding with a hit still counts that hit.
      if (hit_entry) begin
        if (clr_count) begin
          cnt_q <= CNT_W'(1);
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (clr_count) begin
        cnt_q <= '0;
      end

      if (cfg_load) begin
        match_q <= 1'b0;
        if (cfg_legal) begin
          state_q <= SEARCH;
          pat_q   <= cfg_pattern;
          len_q   <= cfg_len;
          ovl_q   <= cfg_overlap;
          hist_q  <= '0;
          fill_q  <= '0;
          err_q   <= 1'b0;
        end else begin
          state_q <= UNCFG;
          err_q   <= 1'b1;
        end
      end else if (state_q == UNCFG) begin
        match_q <= 1'b0;
      end else if (din_valid) begin
        hist_q <= hist_d;
        if (hit) begin
          state_q <= HIT;
          match_q <= 1'b1;
          fill_q  <= ovl_q ? fill_d : '0;
        end else begin
          state_q <= SEARCH;
          match_q <= 1'b0;
          fill_q  <= fill_d;
        end
      end else begin
        state_q <= SEARCH;
        match_q <= 1'b0;
      end
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_moore.sv
// tb/tb_seq_detect_moore.sv - scoreboard bench for seq_detect_moore
// Driver queues the expected time and count of each match; the monitor pops on every match cycle.
module tb_seq_detect_moore;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               clr_count = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  seq_detect_moore #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .din_valid(din_valid), .din(din), .match(match),
    .match_count(match_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint t;
    int     cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic bit_in(input logic b, input logic exp_hit, input int exp_cnt);
    exp_t e;
    din_valid = 1'b1;
    din       = b;
    tick();
    din_valid = 1'b0;
    if (exp_hit) begin
      e.t   = longint'($time) + 4;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // 1,1,0,1,1,0,1,1 against 11011: hits after bits 5 and 8 (overlap) or only 5 (no overlap).
  task automatic stream_11011(input logic ovl, input int gap);
    logic [7:0] bits;
    bits = 8'b11011011;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3)
        bit_in(bits[i], 1'b1, 1);
      else if (i == 0)
        bit_in(bits[i], ovl, 2);
      else
        bit_in(bits[i], 1'b0, 0);
      idle(gap);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].t < longint'($time)) begin
      e = exp_q.pop_front();
      check("missed_match_time", 0, e.t);
    end
    if (match) begin
      if (exp_q.size() == 0) begin
        check("unexpected_match_time", longint'($time), 0);
      end else begin
        e = exp_q.pop_front();
        check("match_time", longint'($time), e.t);
        check("match_count_at_hit", longint'(match_count), longint'(e.cnt));
      end
    end
  end

  initial begin
    do_reset();
    check("reset_match", longint'(match), 0);
    check("reset_count", longint'(match_count), 0);
    check("reset_cfg_err", longint'(cfg_err), 0);
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0);
    idle(2);

    load(8'b0001_1011, 4'd5, 1'b1);
    stream_11011(1'b1, 0);
    idle(2);
    check("overlap_count", longint'(match_count), 2);

    do_reset();
    load(8'b0001_1011, 4'd5, 1'b0);
    stream_11011(1'b0, 0);
    idle(2);
    check("nonoverlap_count", longint'(match_count), 1);

    do_reset();
    load(8'b0001_1011, 4'd5, 1'b1);
    stream_11011(1'b1, 3);
    check("gapped_count", longint'(match_count), 2);

    load(8'b0001_1011, 4'd0, 1'b1);
    check("len0_cfg_err", longint'(cfg_err), 1);
    for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b0, 0);
    load(8'b0001_1011, 4'd9, 1'b1);
    check("len9_cfg_err", longint'(cfg_err), 1);
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b0, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0);
    idle(1);
    check("uncfg_count_held", longint'(match_count), 2);
    load(8'b0000_0001, 4'd1, 1'b1);
    check("legal_clears_cfg_err", longint'(cfg_err), 0);
    check("load_keeps_count", longint'(match_count), 2);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_count", longint'(match_count), 0);

    for (int i = 0; i < 8; i++) bit_in(1'b1, 1'b1, (i < 3) ? i + 1 : 3);
    check("saturated_count", longint'(match_count), 3);
    clr_count = 1'b1;
    bit_in(1'b1, 1'b1, 1);
    clr_count = 1'b0;
    bit_in(1'b1, 1'b1, 2);
    idle(1);
    check("hit_ends_on_idle", longint'(match), 0);

    do_reset();
    load(8'b0001_1011, 4'd5, 1'b1);
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b0, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0);
    din_valid = 1'b1;
    din       = 1'b1;
    load(8'b0001_1011, 4'd5, 1'b1);
    din_valid = 1'b0;
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b0, 1'b0, 0);
    bit_in(1'b1, 1'b0, 0);
    bit_in(1'b1, 1'b1, 1);
    idle(2);

    do_reset();
    load(8'b0000_0001, 4'd1, 1'b1);
    bit_in(1'b1, 1'b1, 1);
    check("in_hit_before_rst", longint'(match), 1);
    do_reset();
    check("rst_in_hit_match", longint'(match), 0);
    check("rst_in_hit_count", longint'(match_count), 0);
    idle(3);

    check("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
